imm_extend_pipe: RTL

Parametrised, pipelined immediate generator that replaces the fixed 12-to-32 sign extender in the datapath. It supports four extension modes: sign-extend, zero-extend, word-offset (sign-extend then shift left by 2) and rotated-immediate (imm8 rotated right by 2*rot4). A registered two-stage pipeline with valid/ready handshakes on both sides lets it sit between decode and execute in the pipelined core.

---
 rtl/imm_ext_pkg.sv | 14 +
 rtl/imm_ext_core.sv | 51 +++++
 rtl/imm_extend_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate generator: extension mode encodings and
// the field layout of the rotated-immediate (imm8 + rot4) form.
package imm_ext_pkg;

  localparam logic [1:0] MODE_SEXT = 2'b00;
  localparam logic [1:0] MODE_ZEXT = 2'b01;
  localparam logic [1:0] MODE_SHL2 = 2'b10;
  localparam logic [1:0] MODE_ROR  = 2'b11;

  localparam int IMM8_LSB = 0;
  localparam int ROT_LSB  = 8;
  localparam int ROT_W    = 4;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension (sign, zero, word-offset, rotated imm8).
// Shared between the pipelined wrapper and the single-cycle datapath.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] data_o,
  output logic             carry_o
);

  localparam int SHW = $clog2(OUT_W);

  logic [OUT_W-1:0] sext_w;
  logic [OUT_W-1:0] zext_w;
  logic [OUT_W-1:0] imm8_w;
  logic [OUT_W-1:0] ror_w;
  logic [ROT_W-1:0] rot_field;
  logic [SHW-1:0]   rsh;
  logic [SHW-1:0]   lsh;

  assign sext_w    = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
  assign zext_w    = {{(OUT_W-IN_W){1'b0}}, imm_i};
  assign imm8_w    = {{(OUT_W-8){1'b0}}, imm_i[IMM8_LSB +: 8]};
  assign rot_field = imm_i[ROT_LSB +: ROT_W];

  // The left amount wraps to zero for power-of-two widths when rsh is zero,
  // which still yields imm8 unchanged since both shifted halves equal imm8.
  assign rsh   = SHW'({rot_field, 1'b0});
  assign lsh   = SHW'(OUT_W) - rsh;
  assign ror_w = (imm8_w >> rsh) | (imm8_w << lsh);

  always_comb begin
    data_o  = '0;
    carry_o = 1'b0;
    case (mode_i)
      MODE_SEXT: data_o = sext_w;
      MODE_ZEXT: data_o = zext_w;
      MODE_SHL2: data_o = {sext_w[OUT_W-3:0], 2'b00};
      MODE_ROR: begin
        data_o  = ror_w;
        carry_o = (rot_field != '0) ? ror_w[OUT_W-1] : 1'b0;
      end
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage registered immediate generator between decode and execute.
// Stage 1 captures the raw field, stage 2 holds the extended result.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_carry
);

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_imm_q, s1_imm_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_data_q, s2_data_d;
  logic             s2_carry_q, s2_carry_d;
  logic [OUT_W-1:0] core_data;
  logic             core_carry;
  logic             s1_adv;
  logic             s2_adv;

  // Handshake: a beat moves on a side when valid && ready in the same cycle.
  // A stage may load when it is empty or its occupant leaves this cycle, so
  // in_ready follows out_ready combinationally; valid never waits on ready.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = rst_n && s1_adv;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm_i   (s1_imm_q),
    .mode_i  (s1_mode_q),
    .data_o  (core_data),
    .carry_o (core_carry)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_carry_d = s2_carry_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d  = core_data;
        s2_carry_d = core_carry;
      end
    end
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_imm_d  = in_imm;
        s1_mode_d = in_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_mode_q  <= MODE_SEXT;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_carry_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_carry_q <= s2_carry_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_carry = s2_carry_q;

endmodule
